ppu_mirror_ram: RTL

//  Parametrised true dual-port PPU RAM with NES nametable mirroring, configurable read latency
//  and a hardware clear sequencer, replacing per-memory init loops (not synthesisable) with a

---
 rtl/ppu_mirror_ram_pkg.sv | 44 ++++
 rtl/ppu_mirror_ram_if.sv | 42 ++++
 rtl/ppu_mirror_ram_map.sv | 22 ++
 rtl/ppu_mirror_ram.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/ppu_mirror_ram_pkg.sv
// ---------------------------------------------------------------------------
// ppu_mem_pkg
// Shared types and constants for the PPU mirrored nametable RAM:
//   mirror_mode_t : nametable mirroring selection driven by the cartridge
//   clr_state_t   : clear sequencer states (sweep running / ready)
//   DEF_*         : default widths used by the RAM, its interface and mapper
//   mirror_tbl()  : selects which physical 1KB table a logical address hits
// ---------------------------------------------------------------------------
package ppu_mem_pkg;

    localparam int unsigned DEF_DATA_W = 8;
    localparam int unsigned DEF_OFF_W  = 10;
    localparam int unsigned DEF_LOG_W  = 12;

    typedef enum logic [1:0] {
        MIR_HORIZ     = 2'd0,
        MIR_VERT      = 2'd1,
        MIR_SINGLE_LO = 2'd2,
        MIR_SINGLE_HI = 2'd3
    } mirror_mode_t;

    typedef enum logic [0:0] {
        CLR_RUN   = 1'b0,
        CLR_READY = 1'b1
    } clr_state_t;

    // a_hi is the logical table-select MSB, a_lo the LSB. Horizontal
    // mirroring pairs tables {0,1} and {2,3}, so the MSB picks the physical
    // table; vertical pairs {0,2} and {1,3}, so the LSB does.
    function automatic logic mirror_tbl(input mirror_mode_t mode,
                                        input logic         a_hi,
                                        input logic         a_lo);
        logic tbl;
        case (mode)
            MIR_HORIZ:     tbl = a_hi;
            MIR_VERT:      tbl = a_lo;
            MIR_SINGLE_LO: tbl = 1'b0;
            MIR_SINGLE_HI: tbl = 1'b1;
            default:       tbl = 1'b0;
        endcase
        return tbl;
    endfunction

endpackage

// File: rtl/ppu_mirror_ram_if.sv
// ---------------------------------------------------------------------------
// ppu_mirror_ram_if
// Bus bundle between the PPU/CPU side and the mirrored nametable RAM.
//   clk_en       : PPU tick enable
//   mirror_mode  : current mirroring mode
//   addr/we/din  : per-port (A = PPU fetch, B = CPU $2007) request
//   dout_a/b     : per-port read data
//   busy         : clear sweep in progress
// Modports: master drives requests, slave is the RAM.
// ---------------------------------------------------------------------------
interface ppu_mirror_ram_if #(
    parameter int unsigned DATA_W = ppu_mem_pkg::DEF_DATA_W,
    parameter int unsigned LOG_W  = ppu_mem_pkg::DEF_LOG_W
) ();

    logic                     clk_en;
    ppu_mem_pkg::mirror_mode_t mirror_mode;
    logic [LOG_W-1:0]         addr_a;
    logic                     we_a;
    logic [DATA_W-1:0]        din_a;
    logic [DATA_W-1:0]        dout_a;
    logic [LOG_W-1:0]         addr_b;
    logic                     we_b;
    logic [DATA_W-1:0]        din_b;
    logic [DATA_W-1:0]        dout_b;
    logic                     busy;

    modport master (
        output clk_en, mirror_mode,
        output addr_a, we_a, din_a,
        output addr_b, we_b, din_b,
        input  dout_a, dout_b, busy
    );

    modport slave (
        input  clk_en, mirror_mode,
        input  addr_a, we_a, din_a,
        input  addr_b, we_b, din_b,
        output dout_a, dout_b, busy
    );

endinterface

// File: rtl/ppu_mirror_ram_map.sv
// ---------------------------------------------------------------------------
// ppu_mirror_map
// Combinational logical -> physical nametable address mapper.
//   mode_i : mirroring mode
//   addr_i : logical address (4 tables x 2**OFF_W)
//   phys_o : physical address {table, offset} into 2 x 2**OFF_W words
// ---------------------------------------------------------------------------
module ppu_mirror_map
    import ppu_mem_pkg::*;
#(
    parameter int unsigned OFF_W = DEF_OFF_W,
    parameter int unsigned LOG_W = DEF_LOG_W
) (
    input  mirror_mode_t     mode_i,
    input  logic [LOG_W-1:0] addr_i,
    output logic [OFF_W:0]   phys_o
);

    assign phys_o = {mirror_tbl(mode_i, addr_i[OFF_W+1], addr_i[OFF_W]),
                     addr_i[OFF_W-1:0]};

endmodule

// File: rtl/ppu_mirror_ram.sv
// ---------------------------------------------------------------------------
// ppu_mirror_ram
// True dual-port PPU nametable RAM with NES mirroring, 1- or 2-tick read
// latency and a post-reset clear sweep that replaces memory init loops.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : ppu_mirror_ram_if slave (clk_en, mirror_mode, ports A/B,
//                dout_a/b, busy)
// Port A carries the clear writes; on a same-address write collision port A
// wins. Reads are read-first: a read sees the word before a same-tick write.
// ---------------------------------------------------------------------------
module ppu_mirror_ram
    import ppu_mem_pkg::*;
#(
    parameter int unsigned       DATA_W    = DEF_DATA_W,
    parameter int unsigned       OFF_W     = DEF_OFF_W,
    parameter int unsigned       LOG_W     = DEF_LOG_W,
    parameter int unsigned       READ_LAT  = 1,
    parameter bit                CLEAR_EN  = 1'b1,
    parameter logic [DATA_W-1:0] CLEAR_VAL = {DATA_W{1'b0}}
) (
    input  logic            clk,
    input  logic            rst_n,
    ppu_mirror_ram_if.slave bus
);

    localparam int unsigned       PHYS_W     = OFF_W + 1;
    localparam int unsigned       PHYS_DEPTH = 1 << PHYS_W;
    localparam logic [PHYS_W-1:0] CNT_MAX    = {PHYS_W{1'b1}};
    localparam clr_state_t        RST_STATE  = CLEAR_EN ? CLR_RUN : CLR_READY;
    localparam logic              RST_BUSY   = CLEAR_EN;

    if (LOG_W != OFF_W + 2) begin : g_bad_log_w
        $error("ppu_mirror_ram: LOG_W must equal OFF_W+2");
    end
    if (READ_LAT != 1 && READ_LAT != 2) begin : g_bad_read_lat
        $error("ppu_mirror_ram: READ_LAT must be 1 or 2");
    end

    logic [DATA_W-1:0] mem [PHYS_DEPTH];

    clr_state_t        state_q, state_d;
    logic [PHYS_W-1:0] cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic [DATA_W-1:0] rd1_a_q, rd1_a_d, rd1_b_q, rd1_b_d;
    logic [DATA_W-1:0] rd2_a_q, rd2_a_d, rd2_b_q, rd2_b_d;

    logic [PHYS_W-1:0] phys_a_s, phys_b_s;
    logic              ready_s;
    logic              wa_en_s, wb_en_s;
    logic [PHYS_W-1:0] wa_addr_s;
    logic [DATA_W-1:0] wa_data_s;

    ppu_mirror_map #(.OFF_W(OFF_W), .LOG_W(LOG_W)) u_map_a (
        .mode_i (bus.mirror_mode),
        .addr_i (bus.addr_a),
        .phys_o (phys_a_s)
    );

    ppu_mirror_map #(.OFF_W(OFF_W), .LOG_W(LOG_W)) u_map_b (
        .mode_i (bus.mirror_mode),
        .addr_i (bus.addr_b),
        .phys_o (phys_b_s)
    );

    assign ready_s = (state_q == CLR_READY);

    // Clear sequencer: one word per tick, leaves RUN on the last word.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        if (bus.clk_en) begin
            case (state_q)
                CLR_RUN: begin
                    if (cnt_q == CNT_MAX) begin
                        state_d = CLR_READY;
                        cnt_d   = {PHYS_W{1'b0}};
                        busy_d  = 1'b0;
                    end else begin
                        cnt_d   = cnt_q + {{(PHYS_W-1){1'b0}}, 1'b1};
                        busy_d  = 1'b1;
                    end
                end
                CLR_READY: begin
                    busy_d = 1'b0;
                end
                default: begin
                    // Unknown state: rerun the sweep so contents are defined.
                    state_d = CLR_RUN;
                    cnt_d   = {PHYS_W{1'b0}};
                    busy_d  = 1'b1;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Write port steering: port A carries the sweep; B yields to A on a
    // same-address collision so the result does not depend on RAM ordering.
    always_comb begin
        wa_en_s   = 1'b0;
        wa_addr_s = phys_a_s;
        wa_data_s = bus.din_a;
        wb_en_s   = 1'b0;
        if (bus.clk_en) begin
            if (ready_s) begin
                wa_en_s = bus.we_a;
                wb_en_s = bus.we_b && !(bus.we_a && (phys_a_s == phys_b_s));
            end else begin
                wa_en_s   = 1'b1;
                wa_addr_s = cnt_q;
                wa_data_s = CLEAR_VAL;
            end
        end else begin
            wa_en_s = 1'b0;
        end
    end

    // Read pipeline: stage 1 is the RAM read register (loads 0 while
    // clearing), stage 2 the optional output register.
    always_comb begin
        rd1_a_d = rd1_a_q;
        rd1_b_d = rd1_b_q;
        rd2_a_d = rd2_a_q;
        rd2_b_d = rd2_b_q;
        if (bus.clk_en) begin
            if (ready_s) begin
                rd1_a_d = mem[phys_a_s];
                rd1_b_d = mem[phys_b_s];
            end else begin
                rd1_a_d = {DATA_W{1'b0}};
                rd1_b_d = {DATA_W{1'b0}};
            end
            rd2_a_d = rd1_a_q;
            rd2_b_d = rd1_b_q;
        end else begin
            rd1_a_d = rd1_a_q;
        end
    end

    // Control and read-pipeline registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RST_STATE;
            cnt_q   <= {PHYS_W{1'b0}};
            busy_q  <= RST_BUSY;
            rd1_a_q <= {DATA_W{1'b0}};
            rd1_b_q <= {DATA_W{1'b0}};
            rd2_a_q <= {DATA_W{1'b0}};
            rd2_b_q <= {DATA_W{1'b0}};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            rd1_a_q <= rd1_a_d;
            rd1_b_q <= rd1_b_d;
            rd2_a_q <= rd2_a_d;
            rd2_b_q <= rd2_b_d;
        end
    end

    // Memory array writes (no reset so it maps onto block RAM).
    always_ff @(posedge clk) begin
        if (wa_en_s) begin
            mem[wa_addr_s] <= wa_data_s;
        end
        if (wb_en_s) begin
            mem[phys_b_s] <= bus.din_b;
        end
    end

    assign bus.dout_a = (READ_LAT == 2) ? rd2_a_q : rd1_a_q;
    assign bus.dout_b = (READ_LAT == 2) ? rd2_b_q : rd1_b_q;
    assign bus.busy   = busy_q;

endmodule
